mips_dmem_mmio: RTL and testbench
=================================

// Module: mips_dmem_mmio
// PURPOSE
//  Data-side memory subsystem directly downstream of the MIPS core's data port. It consumes the
//  core's memwrite/memaddr/writedata and returns readdata. Contains a word RAM, a memory-mapped
//  register window (GPIO, cycle counter, byte TX FIFO, status, EPC), and the overflow-exception capture.
// PARAMETERS
//  DATA_W      32             data/address width; equals DATA_MEM_WIDTH
//  RAM_WORDS   256            RAM depth in 32-bit words, power of 2
//  FIFO_DEPTH  8              TX FIFO entries, power of 2, >=2
//  MMIO_HI     16'hFFFF       memaddr[31:16] value that selects the MMIO window
// PORTS
//  clk                      in   1       clock, rising edge
//  rst                      in   1       reset, synchronous, active-high
//  memwrite                 in   1       core store strobe, sampled at posedge
//  memaddr                  in   DATA_W  byte address; [1:0] ignored (word access only)
//  writedata                in   DATA_W  store data
//  readdata                 out  DATA_W  load data, combinational from memaddr
//  pc                       in   DATA_W  core PC, captured into EPC on exception
//  arth_overflow_exception  in   1       core overflow exception, 1-cycle-or-longer level
//  gpio_out                 out  32      GPIO register
//  tx_valid                 out  1       TX FIFO not empty
//  tx_data                  out  8       FIFO head byte
//  tx_ready                 in   1       consumer accepts head when tx_valid&&tx_ready
// BEHAVIOUR
//  Reset (rst=1 at posedge): gpio_out=0, cycle=0, FIFO empty (tx_valid=0, tx_data=0), stickies=0,
//    EPC=0. RAM contents are not reset.
//  Decode: mmio = (memaddr[31:16]==MMIO_HI); RAM index = memaddr[log2(RAM_WORDS)+1:2]; upper bits
//    alias/wrap.
//  RAM: async read, write at posedge when memwrite && !mmio. Load latency: 0 cycles (same cycle).
//  MMIO map (offset = memaddr[7:0]); unmapped offsets read 0 and ignore writes:
//   0x00 GPIO   RW  gpio_out <= writedata
//   0x04 CYCLE  RW  +1 every cycle, wraps 0xFFFFFFFF->0; a write loads 0 (write beats increment)
//   0x08 TXDATA WO  push writedata[7:0]; reads 0
//   0x0C STATUS R/W1C [0]empty [1]full [2]tx_drop [3]ovf [15:8]count, rest 0; writing 1 to bit2/bit3
//                      clears that bit
//   0x10 EPC    RO  pc latched on the exception that set ovf
//  FIFO: circular, rd/wr ptrs plus count. Push when full is dropped and sets tx_drop, even if a pop
//    happens in the same cycle (full is evaluated on the pre-edge state). Push+pop with count in
//    1..FIFO_DEPTH-1: both occur, count unchanged. Push on empty: tx_valid rises the next cycle.
//    Pop on empty is impossible because tx_valid=0. tx_data holds its value when empty.
//  Exception: arth_overflow_exception && !ovf -> ovf<=1, EPC<=pc. While ovf=1, further exceptions
//    do not update EPC. Exception in the same cycle as a W1C clear of bit3: set wins, and EPC
//    updates only if ovf was 0.
//  Sticky set by hardware and W1C in the same cycle (tx_drop): set wins.
//  Reset asserted mid-stream discards FIFO contents; a push in the reset cycle is ignored.
// STRUCTURE
//  mips_pkg additions: MMIO_HI_C, offset constants (MMIO_GPIO/CYCLE/TXDATA/STATUS/EPC), STATUS bit
//    indices, and typedef mmio_off_t (logic[7:0]).
//  Sub-module mips_sync_fifo: params WIDTH, DEPTH. Ports push, din, pop, dout, full, empty, count.
//    Sync active-high reset. Top level holds the RAM array, decode, registers and read mux.
// TESTING
//  1 reset, then SW 0x1234_5678 @0x40 and LW @0x40 -> readdata=0x12345678 the same cycle after
//    the write edge; LW @0x440 (RAM_WORDS=256) aliases 0x40.
//  2 SW 0xA5 @0xFFFF0000 -> gpio_out=0xA5 next cycle; RAM word 0 unchanged. LW @0xFFFF0020 -> 0.
//  3 tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS=0x0000_0806 (count=8, full, tx_drop). Then
//    tx_ready=1 -> tx_data 0x01..0x08 on consecutive cycles, then tx_valid=0.
//  4 FIFO full with tx_ready=1 and a push in the same cycle -> byte dropped, tx_drop=1, count=7
//    next cycle. Write 0x4 to STATUS -> tx_drop=0.
//  5 pulse arth_overflow_exception with pc=0x100, then again with pc=0x200 -> EPC=0x100, STATUS[3]=1.
//    W1C bit3 in the same cycle as a new exception at pc=0x300 -> ovf stays 1, EPC=0x100.
//  6 write CYCLE at t, read at t+5 -> 5. Force counter to 0xFFFFFFFF -> reads 0 the next cycle.
//    Assert rst with the FIFO holding 3 bytes -> empty, gpio_out=0.

Source files
------------

// File: rtl/mips_dmem_mmio_pkg.sv
// Shared constants for the MIPS data-side memory subsystem: MMIO window
// select value, register offsets inside the window and STATUS bit positions.
package mips_dmem_mmio_pkg;

  typedef logic [7:0] mmio_off_t;

  localparam logic [15:0] MMIO_HI_C = 16'hFFFF;

  localparam mmio_off_t MMIO_GPIO   = 8'h00;
  localparam mmio_off_t MMIO_CYCLE  = 8'h04;
  localparam mmio_off_t MMIO_TXDATA = 8'h08;
  localparam mmio_off_t MMIO_STATUS = 8'h0C;
  localparam mmio_off_t MMIO_EPC    = 8'h10;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_TX_DROP   = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/mips_dmem_mmio_fifo.sv
// Small circular FIFO used as the byte TX queue. Pushes into a full FIFO
// are discarded (full is judged on the pre-edge state), and the output
// holds the last popped entry while the FIFO is empty.
module mips_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] head_hold;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? head_hold : mem[rd_ptr];

  // Storage array: no reset needed, writes are blocked during reset
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the held head value
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_hold <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        head_hold <= mem[rd_ptr];
      end
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/mips_dmem_mmio.sv
// Data-side memory subsystem for the MIPS core: word RAM with async read,
// a memory-mapped register window (GPIO, cycle counter, TX byte FIFO,
// STATUS, EPC) and capture of the arithmetic overflow exception.
module mips_dmem_mmio
  import mips_dmem_mmio_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_HI    = MMIO_HI_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] memaddr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] pc,
  input  logic              arth_overflow_exception,
  output logic [31:0]       gpio_out,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic              mmio;
  mmio_off_t         off;
  logic [IDX_W-1:0]  ram_idx;
  logic              wr_gpio;
  logic              wr_cycle;
  logic              wr_tx;
  logic              wr_status;
  logic [DATA_W-1:0] gpio_q;
  logic [DATA_W-1:0] cycle_cnt;
  logic [DATA_W-1:0] epc;
  logic              tx_drop;
  logic              ovf;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              tx_pop;
  logic              drop_set;
  logic [DATA_W-1:0] status_word;
  logic              unused_addr_bits;

  assign mmio      = (memaddr[DATA_W-1:DATA_W-16] == MMIO_HI);
  assign off       = memaddr[7:0];
  assign ram_idx   = memaddr[IDX_W+1:2];
  assign wr_gpio   = memwrite && mmio && (off == MMIO_GPIO);
  assign wr_cycle  = memwrite && mmio && (off == MMIO_CYCLE);
  assign wr_tx     = memwrite && mmio && (off == MMIO_TXDATA);
  assign wr_status = memwrite && mmio && (off == MMIO_STATUS);
  assign tx_valid  = !fifo_empty;
  assign tx_pop    = tx_valid && tx_ready;
  assign drop_set  = wr_tx && fifo_full;
  assign gpio_out  = gpio_q;
  assign unused_addr_bits = &{1'b0, memaddr};

  mips_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .din   (writedata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Word RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (memwrite && !mmio) ram[ram_idx] <= writedata;
  end

  // MMIO registers; hardware sets of sticky bits take priority over W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q    <= '0;
      cycle_cnt <= '0;
      tx_drop   <= 1'b0;
      ovf       <= 1'b0;
      epc       <= '0;
    end else begin
      if (wr_gpio) gpio_q <= writedata;
      cycle_cnt <= wr_cycle ? '0 : cycle_cnt + 1'b1;
      if (drop_set) tx_drop <= 1'b1;
      else if (wr_status && writedata[ST_TX_DROP]) tx_drop <= 1'b0;
      if (arth_overflow_exception) begin
        ovf <= 1'b1;
        if (!ovf) epc <= pc;
      end else if (wr_status && writedata[ST_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    status_word = '0;
    status_word[ST_EMPTY]   = fifo_empty;
    status_word[ST_FULL]    = fifo_full;
    status_word[ST_TX_DROP] = tx_drop;
    status_word[ST_OVF]     = ovf;
    status_word[ST_COUNT_LSB +: CNT_W] = fifo_count;
  end

  // Zero-latency load mux between the MMIO window and the RAM
  always_comb begin
    readdata = '0;
    if (mmio) begin
      case (off)
        MMIO_GPIO:   readdata = gpio_q;
        MMIO_CYCLE:  readdata = cycle_cnt;
        MMIO_STATUS: readdata = status_word;
        MMIO_EPC:    readdata = epc;
        default:     readdata = '0;
      endcase
    end else begin
      readdata = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_mips_dmem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] pc;
  logic        arth_overflow_exception;
  logic [31:0] gpio_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] A_GPIO   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] A_EPC    = 32'hFFFF_0010;

  always #5 clk = ~clk;

  mips_dmem_mmio dut (
    .clk                     (clk),
    .rst                     (rst),
    .memwrite                (memwrite),
    .memaddr                 (memaddr),
    .writedata               (writedata),
    .readdata                (readdata),
    .pc                      (pc),
    .arth_overflow_exception (arth_overflow_exception),
    .gpio_out                (gpio_out),
    .tx_valid                (tx_valid),
    .tx_data                 (tx_data),
    .tx_ready                (tx_ready)
  );

  // Reference model state
  logic [31:0] m_ram [256];
  bit          m_known [256];
  logic [31:0] m_gpio;
  logic [31:0] m_cycle;
  logic [31:0] m_epc;
  bit          m_drop;
  bit          m_ovf;
  logic [7:0]  m_fifo [$];
  logic [7:0]  m_last;

  // Reference model advances on every rising edge from the current inputs
  always @(posedge clk) begin : ref_model
    bit          in_mmio;
    int          offset;
    int          widx;
    bit          was_full;
    bit          popping;
    bit          ovf_before;
    if (rst) begin
      m_gpio  = 0;
      m_cycle = 0;
      m_fifo.delete();
      m_drop  = 0;
      m_ovf   = 0;
      m_epc   = 0;
      m_last  = 0;
    end else begin
      in_mmio    = (memaddr >> 16) == 32'h0000_FFFF;
      offset     = int'(memaddr % 256);
      widx       = int'((memaddr / 4) % 256);
      was_full   = (m_fifo.size() == 8);
      popping    = tx_ready && (m_fifo.size() > 0);
      ovf_before = m_ovf;
      if (memwrite && !in_mmio) begin
        m_ram[widx]   = writedata;
        m_known[widx] = 1;
      end
      if (memwrite && in_mmio && offset == 4) m_cycle = 0;
      else m_cycle = m_cycle + 1;
      if (memwrite && in_mmio && offset == 0) m_gpio = writedata;
      if (popping) m_last = m_fifo.pop_front();
      if (memwrite && in_mmio && offset == 12) begin
        if (writedata[2]) m_drop = 0;
        if (writedata[3]) m_ovf = 0;
      end
      if (memwrite && in_mmio && offset == 8) begin
        if (was_full) m_drop = 1;
        else m_fifo.push_back(writedata[7:0]);
      end
      if (arth_overflow_exception) begin
        if (!ovf_before) m_epc = pc;
        m_ovf = 1;
      end
    end
  end

  function automatic logic [31:0] m_status();
    int sz;
    sz = m_fifo.size();
    return (32'(sz) * 256) + (m_ovf ? 32'd8 : 32'd0) + (m_drop ? 32'd4 : 32'd0)
         + ((sz == 8) ? 32'd2 : 32'd0) + ((sz == 0) ? 32'd1 : 32'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if ((a >> 16) == 32'h0000_FFFF) begin
      case (a % 256)
        0:       return m_gpio;
        4:       return m_cycle;
        12:      return m_status();
        16:      return m_epc;
        default: return 32'h0;
      endcase
    end
    return m_ram[(a / 4) % 256];
  endfunction

  function automatic logic [7:0] m_tx_data();
    if (m_fifo.size() > 0) return m_fifo[0];
    return m_last;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    memaddr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memaddr = a;
    #1;
    check_output(tag, readdata, exp);
  endtask

  initial begin
    logic [7:0] offs [6];
    logic [31:0] a;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h24};

    rst = 1'b1; memwrite = 1'b0; memaddr = 32'h0; writedata = 32'h0;
    pc = 32'h0; arth_overflow_exception = 1'b0; tx_ready = 1'b0;
    $display("[TB] reset");
    repeat (2) tick();
    check_output("rst_gpio", gpio_out, 32'h0);
    check_output("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check_output("rst_tx_data", {24'b0, tx_data}, 32'h0);
    rst = 1'b0;
    read_check("rst_status", A_STATUS, 32'h1);
    read_check("rst_epc", A_EPC, 32'h0);

    $display("[TB] ram store/load");
    apply_stimulus(1'b1, 32'h0, 32'hDEAD_BEEF);
    memwrite = 1'b1; memaddr = 32'h40; writedata = 32'h1234_5678;
    tick();
    check_output("ram_same_cycle", readdata, 32'h1234_5678);
    memwrite = 1'b0;
    read_check("ram_alias_440", 32'h440, 32'h1234_5678);

    $display("[TB] gpio");
    apply_stimulus(1'b1, A_GPIO, 32'hA5);
    check_output("gpio_out", gpio_out, 32'hA5);
    read_check("gpio_read", A_GPIO, 32'hA5);
    read_check("ram_word0_kept", 32'h0, 32'hDEAD_BEEF);
    read_check("unmapped_read", 32'hFFFF_0020, 32'h0);

    $display("[TB] fifo overflow and drain");
    for (int i = 1; i <= 9; i++) apply_stimulus(1'b1, A_TXDATA, 32'(i));
    read_check("status_full", A_STATUS, 32'h0000_0806);
    read_check("txdata_reads0", A_TXDATA, 32'h0);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_output("drain_valid", {31'b0, tx_valid}, 32'h1);
      check_output("drain_data", {24'b0, tx_data}, 32'(i));
      tick();
    end
    check_output("drained_valid", {31'b0, tx_valid}, 32'h0);
    check_output("drained_hold", {24'b0, tx_data}, 32'h8);
    tx_ready = 1'b0;
    apply_stimulus(1'b1, A_STATUS, 32'h4);
    read_check("drop_cleared", A_STATUS, 32'h1);

    $display("[TB] push while full with pop");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, A_TXDATA, 32'h10 + 32'(i));
    read_check("status_full8", A_STATUS, 32'h0000_0802);
    tx_ready = 1'b1; memwrite = 1'b1; memaddr = A_TXDATA; writedata = 32'h77;
    tick();
    memwrite = 1'b0; tx_ready = 1'b0;
    read_check("full_push_pop", A_STATUS, 32'h0000_0704);
    apply_stimulus(1'b1, A_STATUS, 32'h4);
    read_check("drop_w1c", A_STATUS, 32'h0000_0700);
    tx_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      check_output("drain2_data", {24'b0, tx_data}, 32'h10 + 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    check_output("drain2_valid", {31'b0, tx_valid}, 32'h0);

    $display("[TB] overflow exception");
    pc = 32'h100; arth_overflow_exception = 1'b1; tick();
    arth_overflow_exception = 1'b0; tick();
    pc = 32'h200; arth_overflow_exception = 1'b1; tick();
    arth_overflow_exception = 1'b0;
    read_check("epc_first", A_EPC, 32'h100);
    read_check("ovf_set", A_STATUS, 32'h9);
    pc = 32'h300; arth_overflow_exception = 1'b1;
    apply_stimulus(1'b1, A_STATUS, 32'h8);
    arth_overflow_exception = 1'b0;
    read_check("epc_set_wins", A_EPC, 32'h100);
    read_check("ovf_set_wins", A_STATUS, 32'h9);
    apply_stimulus(1'b1, A_STATUS, 32'h8);
    read_check("ovf_w1c", A_STATUS, 32'h1);
    pc = 32'h400; arth_overflow_exception = 1'b1; tick();
    arth_overflow_exception = 1'b0;
    read_check("epc_recapture", A_EPC, 32'h400);

    $display("[TB] cycle counter");
    apply_stimulus(1'b1, A_CYCLE, 32'hFFFF);
    read_check("cycle_write0", A_CYCLE, 32'h0);
    repeat (5) tick();
    read_check("cycle_plus5", A_CYCLE, 32'h5);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    read_check("cycle_forced", A_CYCLE, 32'hFFFF_FFFF);
    tick();
    read_check("cycle_wrap", A_CYCLE, 32'h0);
    apply_stimulus(1'b1, A_CYCLE, 32'h0);
    read_check("cycle_resync", A_CYCLE, m_read(A_CYCLE));

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, A_TXDATA, 32'hC0 + 32'(i));
    rst = 1'b1; memwrite = 1'b1; memaddr = A_TXDATA; writedata = 32'h55;
    tick();
    rst = 1'b0; memwrite = 1'b0;
    check_output("rst2_valid", {31'b0, tx_valid}, 32'h0);
    check_output("rst2_gpio", gpio_out, 32'h0);
    check_output("rst2_tx_data", {24'b0, tx_data}, 32'h0);
    read_check("rst2_status", A_STATUS, 32'h1);

    $display("[TB] randomized run");
    for (int n = 0; n < 400; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      arth_overflow_exception = ($urandom_range(0, 15) == 0);
      pc = $urandom;
      memwrite = 1'($urandom_range(0, 1));
      writedata = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = {16'hFFFF, 8'($urandom), offs[$urandom_range(0, 5)]};
      end else begin
        a = $urandom;
        if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
      end
      memaddr = a;
      #1;
      if (a[31:16] == 16'hFFFF || m_known[(a / 4) % 256])
        check_output("rand_readdata", readdata, m_read(a));
      check_output("rand_tx_valid", {31'b0, tx_valid}, {31'b0, m_fifo.size() > 0});
      check_output("rand_tx_data", {24'b0, tx_data}, {24'b0, m_tx_data()});
      check_output("rand_gpio", gpio_out, m_gpio);
      tick();
    end
    memwrite = 1'b0;
    arth_overflow_exception = 1'b0;
    read_check("final_status", A_STATUS, m_status());
    read_check("final_epc", A_EPC, m_epc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
